// File: rtl/riscv_mem_pkg.sv
// Shared types for the IFU/LSU memory arbiter: requester identity and owner FIFO entry.
package riscv_mem_pkg;

    localparam int DEPTH_DEFAULT = 16;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    typedef struct packed {
        owner_e owner;
        logic   discard;
    } owner_entry_s;

endpackage

// File: rtl/riscv_owner_fifo.sv
// In-order record of which requester owns each request outstanding in the driver,
// with a per-owner broadcast that marks that owner's entries as discarded.
module riscv_owner_fifo
    import riscv_mem_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic          push_owner,
    input  logic          pop,
    input  logic          flush_ifu,
    input  logic          flush_lsu,
    output logic          head_owner,
    output logic          head_discard,
    output logic [CW-1:0] count
);

    localparam int AW = CW - 1;

    owner_entry_s  mem [DEPTH];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;

    assign count        = wr_ptr - rd_ptr;
    assign head_owner   = mem[rd_ptr[AW-1:0]].owner;
    assign head_discard = mem[rd_ptr[AW-1:0]].discard;

    // Stale slots may also be marked on a flush; a push always rewrites its slot with discard clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((mem[i].owner == OWN_IFU && flush_ifu) || (mem[i].owner == OWN_LSU && flush_lsu)) begin
                    mem[i].discard <= 1'b1;
                end
            end
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= '{owner: owner_e'(push_owner), discard: 1'b0};
                wr_ptr              <= wr_ptr + CW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Round-robin IFU/LSU arbiter in front of the AXI memory driver; steers in-order
// responses back to their owner and drops responses of a flushed requester.
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          ifu_req_vld,
    input  logic [31:0]   ifu_req_addr,
    output logic          ifu_req_ack,
    output logic          ifu_rsp_vld,
    output logic [31:0]   ifu_rsp_addr,
    output logic [31:0]   ifu_rsp_data,
    input  logic          ifu_rsp_ack,
    input  logic          ifu_flush,
    input  logic          lsu_req_vld,
    input  logic          lsu_req_rnw,
    input  logic [31:0]   lsu_req_addr,
    input  logic [31:0]   lsu_req_data,
    output logic          lsu_req_ack,
    output logic          lsu_rsp_vld,
    output logic [31:0]   lsu_rsp_addr,
    output logic [31:0]   lsu_rsp_data,
    input  logic          lsu_rsp_ack,
    input  logic          lsu_flush,
    output logic          drv_req_vld,
    output logic          drv_req_rnw,
    output logic [31:0]   drv_req_addr,
    output logic [31:0]   drv_req_data,
    input  logic          drv_req_ack,
    input  logic          drv_rsp_vld,
    input  logic [31:0]   drv_rsp_addr,
    input  logic [31:0]   drv_rsp_data,
    output logic          drv_rsp_ack,
    output logic [CW-1:0] ifu_outstanding,
    output logic [CW-1:0] lsu_outstanding,
    output logic          idle
);

    owner_e        last_grant;
    logic          ifu_elig;
    logic          lsu_elig;
    logic          win_lsu;
    logic          accept;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] count;
    logic          head_owner;
    logic          head_discard;
    logic          head_flush;
    logic          rsp_live;
    logic          head_deliver;
    logic          pop_live;

    assign ifu_elig   = ifu_req_vld & ~ifu_flush;
    assign lsu_elig   = lsu_req_vld & ~lsu_flush;
    assign win_lsu    = lsu_elig & (~ifu_elig | (last_grant == OWN_IFU));
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(DEPTH));

    // Outputs are gated by reset_n so nothing is handshaken while reset is held.
    assign drv_req_vld  = reset_n & (ifu_elig | lsu_elig) & ~fifo_full;
    assign drv_req_rnw  = win_lsu ? lsu_req_rnw  : 1'b1;
    assign drv_req_addr = win_lsu ? lsu_req_addr : ifu_req_addr;
    assign drv_req_data = win_lsu ? lsu_req_data : 32'h0;
    assign accept       = drv_req_vld & drv_req_ack;
    assign ifu_req_ack  = accept & ~win_lsu;
    assign lsu_req_ack  = accept & win_lsu;

    assign head_flush   = head_owner ? lsu_flush : ifu_flush;
    assign rsp_live     = reset_n & drv_rsp_vld & ~fifo_empty;
    assign head_deliver = rsp_live & ~head_discard & ~head_flush;
    assign ifu_rsp_vld  = head_deliver & ~head_owner;
    assign lsu_rsp_vld  = head_deliver & head_owner;
    assign drv_rsp_ack  = rsp_live & (head_discard | head_flush |
                                      (head_owner ? lsu_rsp_ack : ifu_rsp_ack));
    assign ifu_rsp_addr = drv_rsp_addr;
    assign ifu_rsp_data = drv_rsp_data;
    assign lsu_rsp_addr = drv_rsp_addr;
    assign lsu_rsp_data = drv_rsp_data;
    assign idle         = fifo_empty;
    assign pop_live     = drv_rsp_ack & ~head_discard;

    riscv_owner_fifo #(.DEPTH(DEPTH)) u_owner_fifo (
        .clock        (clock),
        .reset_n      (reset_n),
        .push         (accept),
        .push_owner   (win_lsu),
        .pop          (drv_rsp_ack),
        .flush_ifu    (ifu_flush),
        .flush_lsu    (lsu_flush),
        .head_owner   (head_owner),
        .head_discard (head_discard),
        .count        (count)
    );

    // A flushed owner cannot push in its own flush cycle, so clearing to zero is exact.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant      <= OWN_IFU;
            ifu_outstanding <= '0;
            lsu_outstanding <= '0;
        end else begin
            if (accept) begin
                last_grant <= win_lsu ? OWN_LSU : OWN_IFU;
            end
            if (ifu_flush) begin
                ifu_outstanding <= '0;
            end else begin
                ifu_outstanding <= ifu_outstanding + CW'(ifu_req_ack) - CW'(pop_live & ~head_owner);
            end
            if (lsu_flush) begin
                lsu_outstanding <= '0;
            end else begin
                lsu_outstanding <= lsu_outstanding + CW'(lsu_req_ack) - CW'(pop_live & head_owner);
            end
        end
    end

    a_rsp_has_owner: assert property (@(posedge clock) disable iff (!reset_n)
                                      !(drv_rsp_vld && fifo_empty));

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed scenarios plus a randomized run against a queue-based model of the arbiter.
module tb_riscv_mem_arbiter;

    localparam int DEPTH = 16;
    localparam int CW    = 5;

    typedef struct {
        logic        own;   // 1 = LSU
        logic        disc;
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    logic          clock;
    logic          reset_n;
    logic          ifu_req_vld, ifu_req_ack, ifu_rsp_vld, ifu_rsp_ack, ifu_flush;
    logic [31:0]   ifu_req_addr, ifu_rsp_addr, ifu_rsp_data;
    logic          lsu_req_vld, lsu_req_rnw, lsu_req_ack, lsu_rsp_vld, lsu_rsp_ack, lsu_flush;
    logic [31:0]   lsu_req_addr, lsu_req_data, lsu_rsp_addr, lsu_rsp_data;
    logic          drv_req_vld, drv_req_rnw, drv_req_ack, drv_rsp_vld, drv_rsp_ack;
    logic [31:0]   drv_req_addr, drv_req_data, drv_rsp_addr, drv_rsp_data;
    logic [CW-1:0] ifu_outstanding, lsu_outstanding;
    logic          idle;

    int total = 0;
    int bad   = 0;

    riscv_mem_arbiter #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .ifu_req_vld(ifu_req_vld), .ifu_req_addr(ifu_req_addr), .ifu_req_ack(ifu_req_ack),
        .ifu_rsp_vld(ifu_rsp_vld), .ifu_rsp_addr(ifu_rsp_addr), .ifu_rsp_data(ifu_rsp_data),
        .ifu_rsp_ack(ifu_rsp_ack), .ifu_flush(ifu_flush),
        .lsu_req_vld(lsu_req_vld), .lsu_req_rnw(lsu_req_rnw), .lsu_req_addr(lsu_req_addr),
        .lsu_req_data(lsu_req_data), .lsu_req_ack(lsu_req_ack),
        .lsu_rsp_vld(lsu_rsp_vld), .lsu_rsp_addr(lsu_rsp_addr), .lsu_rsp_data(lsu_rsp_data),
        .lsu_rsp_ack(lsu_rsp_ack), .lsu_flush(lsu_flush),
        .drv_req_vld(drv_req_vld), .drv_req_rnw(drv_req_rnw), .drv_req_addr(drv_req_addr),
        .drv_req_data(drv_req_data), .drv_req_ack(drv_req_ack),
        .drv_rsp_vld(drv_rsp_vld), .drv_rsp_addr(drv_rsp_addr), .drv_rsp_data(drv_rsp_data),
        .drv_rsp_ack(drv_rsp_ack),
        .ifu_outstanding(ifu_outstanding), .lsu_outstanding(lsu_outstanding), .idle(idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle_inputs();
        ifu_req_vld = 0; ifu_req_addr = 0; ifu_rsp_ack = 0; ifu_flush = 0;
        lsu_req_vld = 0; lsu_req_rnw = 1; lsu_req_addr = 0; lsu_req_data = 0;
        lsu_rsp_ack = 0; lsu_flush = 0;
        drv_req_ack = 0; drv_rsp_vld = 0; drv_rsp_addr = 0; drv_rsp_data = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        repeat (2) step();
        reset_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        step();
        ifu_req_vld = 1; lsu_req_vld = 1; drv_req_ack = 1; drv_rsp_vld = 1;
        ifu_rsp_ack = 1; lsu_rsp_ack = 1;
        settle();
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle: got %b exp 1", idle); end
        total++; if (drv_req_vld !== 1'b0) begin bad++; $display("FAIL reset_drv_req_vld: got %b exp 0", drv_req_vld); end
        total++; if (ifu_req_ack !== 1'b0 || lsu_req_ack !== 1'b0) begin bad++; $display("FAIL reset_req_ack: got %b%b exp 00", ifu_req_ack, lsu_req_ack); end
        total++; if (drv_rsp_ack !== 1'b0 || ifu_rsp_vld !== 1'b0 || lsu_rsp_vld !== 1'b0) begin bad++; $display("FAIL reset_rsp: got %b%b%b exp 000", drv_rsp_ack, ifu_rsp_vld, lsu_rsp_vld); end
        total++; if (ifu_outstanding !== 5'd0 || lsu_outstanding !== 5'd0) begin bad++; $display("FAIL reset_outstanding: got %0d/%0d exp 0/0", ifu_outstanding, lsu_outstanding); end
        do_reset();
    endtask

    task automatic test_ifu_only();
        logic [31:0] addrs [2];
        logic [31:0] datas [2];
        addrs[0] = 32'h100; addrs[1] = 32'h104;
        datas[0] = 32'hA;   datas[1] = 32'hB;
        do_reset();
        drv_req_ack = 1;
        for (int i = 0; i < 2; i++) begin
            ifu_req_vld = 1; ifu_req_addr = addrs[i];
            settle();
            total++; if (ifu_req_ack !== 1'b1 || drv_req_addr !== addrs[i] || drv_req_rnw !== 1'b1) begin bad++; $display("FAIL ifu_only_req%0d: got ack=%b addr=%h rnw=%b exp 1 %h 1", i, ifu_req_ack, drv_req_addr, drv_req_rnw, addrs[i]); end
            step();
        end
        idle_inputs();
        settle();
        total++; if (ifu_outstanding !== 5'd2) begin bad++; $display("FAIL ifu_only_outstanding: got %0d exp 2", ifu_outstanding); end
        ifu_rsp_ack = 1;
        for (int i = 0; i < 2; i++) begin
            drv_rsp_vld = 1; drv_rsp_addr = addrs[i]; drv_rsp_data = datas[i];
            settle();
            total++; if (ifu_rsp_vld !== 1'b1 || ifu_rsp_data !== datas[i] || lsu_rsp_vld !== 1'b0 || drv_rsp_ack !== 1'b1) begin bad++; $display("FAIL ifu_only_rsp%0d: got vld=%b data=%h lsu=%b ack=%b exp 1 %h 0 1", i, ifu_rsp_vld, ifu_rsp_data, lsu_rsp_vld, drv_rsp_ack, datas[i]); end
            step();
        end
        idle_inputs();
        settle();
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL ifu_only_idle: got %b exp 1", idle); end
    endtask

    task automatic test_round_robin();
        do_reset();
        ifu_req_vld = 1; ifu_req_addr = 32'h1000;
        lsu_req_vld = 1; lsu_req_addr = 32'h2000; lsu_req_rnw = 1;
        drv_req_ack = 1;
        for (int i = 0; i < 4; i++) begin
            logic exp_lsu;
            exp_lsu = (i % 2 == 0);
            settle();
            total++; if (lsu_req_ack !== exp_lsu || ifu_req_ack !== !exp_lsu || drv_req_addr !== (exp_lsu ? 32'h2000 : 32'h1000)) begin bad++; $display("FAIL rr_grant%0d: got lsu=%b ifu=%b addr=%h exp lsu=%b", i, lsu_req_ack, ifu_req_ack, drv_req_addr, exp_lsu); end
            step();
        end
        idle_inputs();
        ifu_rsp_ack = 1; lsu_rsp_ack = 1;
        for (int i = 0; i < 4; i++) begin
            logic exp_lsu;
            exp_lsu = (i % 2 == 0);
            drv_rsp_vld = 1; drv_rsp_data = 32'h50 + i;
            settle();
            total++; if (lsu_rsp_vld !== exp_lsu || ifu_rsp_vld !== !exp_lsu || (exp_lsu ? lsu_rsp_data : ifu_rsp_data) !== 32'h50 + i) begin bad++; $display("FAIL rr_steer%0d: got lsu=%b ifu=%b exp lsu=%b", i, lsu_rsp_vld, ifu_rsp_vld, exp_lsu); end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_fill();
        do_reset();
        ifu_req_vld = 1; ifu_req_addr = 32'h3000; drv_req_ack = 1;
        repeat (DEPTH) step();
        settle();
        total++; if (ifu_outstanding !== 5'd16 || idle !== 1'b0) begin bad++; $display("FAIL fill_count: got %0d idle=%b exp 16 0", ifu_outstanding, idle); end
        total++; if (drv_req_vld !== 1'b0 || ifu_req_ack !== 1'b0) begin bad++; $display("FAIL fill_block: got vld=%b ack=%b exp 0 0", drv_req_vld, ifu_req_ack); end
        step();
        drv_rsp_vld = 1; ifu_rsp_ack = 1;
        settle();
        total++; if (drv_rsp_ack !== 1'b1 || drv_req_vld !== 1'b0) begin bad++; $display("FAIL fill_pop_same_cycle: got rsp_ack=%b req_vld=%b exp 1 0", drv_rsp_ack, drv_req_vld); end
        step();
        drv_rsp_vld = 0;
        settle();
        total++; if (drv_req_vld !== 1'b1 || ifu_req_ack !== 1'b1) begin bad++; $display("FAIL fill_reissue: got vld=%b ack=%b exp 1 1", drv_req_vld, ifu_req_ack); end
        step();
        idle_inputs();
        settle();
        total++; if (ifu_outstanding !== 5'd16) begin bad++; $display("FAIL fill_refilled: got %0d exp 16", ifu_outstanding); end
    endtask

    task automatic test_mixed_flush();
        do_reset();
        drv_req_ack = 1;
        ifu_req_vld = 1; ifu_req_addr = 32'h200;
        settle();
        total++; if (ifu_req_ack !== 1'b1) begin bad++; $display("FAIL mixed_ifu0_ack: got %b exp 1", ifu_req_ack); end
        step();
        ifu_req_vld = 0;
        lsu_req_vld = 1; lsu_req_rnw = 0; lsu_req_addr = 32'h300; lsu_req_data = 32'h1234;
        settle();
        total++; if (lsu_req_ack !== 1'b1 || drv_req_rnw !== 1'b0 || drv_req_data !== 32'h1234) begin bad++; $display("FAIL mixed_lsu_write: got ack=%b rnw=%b data=%h exp 1 0 1234", lsu_req_ack, drv_req_rnw, drv_req_data); end
        step();
        lsu_req_vld = 0;
        ifu_req_vld = 1; ifu_req_addr = 32'h204;
        step();
        idle_inputs();
        settle();
        total++; if (ifu_outstanding !== 5'd2 || lsu_outstanding !== 5'd1) begin bad++; $display("FAIL mixed_pre_flush: got %0d/%0d exp 2/1", ifu_outstanding, lsu_outstanding); end
        ifu_flush = 1;
        step();
        ifu_flush = 0;
        settle();
        total++; if (ifu_outstanding !== 5'd0 || lsu_outstanding !== 5'd1) begin bad++; $display("FAIL mixed_post_flush: got %0d/%0d exp 0/1", ifu_outstanding, lsu_outstanding); end
        lsu_rsp_ack = 1;
        drv_rsp_vld = 1; drv_rsp_addr = 32'h200; drv_rsp_data = 32'h11;
        settle();
        total++; if (ifu_rsp_vld !== 1'b0 || drv_rsp_ack !== 1'b1) begin bad++; $display("FAIL mixed_discard0: got vld=%b ack=%b exp 0 1", ifu_rsp_vld, drv_rsp_ack); end
        step();
        drv_rsp_addr = 32'h300; drv_rsp_data = 32'h22;
        settle();
        total++; if (lsu_rsp_vld !== 1'b1 || lsu_rsp_addr !== 32'h300 || drv_rsp_ack !== 1'b1) begin bad++; $display("FAIL mixed_lsu_rsp: got vld=%b addr=%h ack=%b exp 1 300 1", lsu_rsp_vld, lsu_rsp_addr, drv_rsp_ack); end
        step();
        drv_rsp_addr = 32'h204; drv_rsp_data = 32'h33;
        settle();
        total++; if (ifu_rsp_vld !== 1'b0 || drv_rsp_ack !== 1'b1) begin bad++; $display("FAIL mixed_discard1: got vld=%b ack=%b exp 0 1", ifu_rsp_vld, drv_rsp_ack); end
        step();
        idle_inputs();
        settle();
        total++; if (idle !== 1'b1 || lsu_outstanding !== 5'd0) begin bad++; $display("FAIL mixed_idle: got idle=%b lsu=%0d exp 1 0", idle, lsu_outstanding); end
    endtask

    task automatic test_flush_head();
        do_reset();
        drv_req_ack = 1;
        ifu_req_vld = 1; ifu_req_addr = 32'h400;
        step();
        ifu_req_addr = 32'h404; ifu_flush = 1; ifu_rsp_ack = 0;
        drv_rsp_vld = 1; drv_rsp_addr = 32'h400; drv_rsp_data = 32'h44;
        settle();
        total++; if (ifu_rsp_vld !== 1'b0 || drv_rsp_ack !== 1'b1) begin bad++; $display("FAIL flush_head_rsp: got vld=%b ack=%b exp 0 1", ifu_rsp_vld, drv_rsp_ack); end
        total++; if (ifu_req_ack !== 1'b0 || drv_req_vld !== 1'b0) begin bad++; $display("FAIL flush_head_req: got ack=%b vld=%b exp 0 0", ifu_req_ack, drv_req_vld); end
        step();
        idle_inputs();
        settle();
        total++; if (idle !== 1'b1 || ifu_outstanding !== 5'd0) begin bad++; $display("FAIL flush_head_idle: got idle=%b out=%0d exp 1 0", idle, ifu_outstanding); end
    endtask

    task automatic test_async_reset();
        do_reset();
        ifu_req_vld = 1; ifu_req_addr = 32'h500;
        lsu_req_vld = 1; lsu_req_addr = 32'h600; lsu_req_rnw = 1;
        drv_req_ack = 1;
        repeat (5) step();
        total++; if (ifu_outstanding !== 5'd2 || lsu_outstanding !== 5'd3) begin bad++; $display("FAIL areset_pre: got %0d/%0d exp 2/3", ifu_outstanding, lsu_outstanding); end
        #2;
        reset_n = 0;
        #1;
        total++; if (idle !== 1'b1 || ifu_outstanding !== 5'd0 || lsu_outstanding !== 5'd0) begin bad++; $display("FAIL areset_clear: got idle=%b %0d/%0d exp 1 0/0", idle, ifu_outstanding, lsu_outstanding); end
        total++; if (ifu_req_ack !== 1'b0 || lsu_req_ack !== 1'b0 || drv_req_vld !== 1'b0) begin bad++; $display("FAIL areset_acks: got %b%b%b exp 000", ifu_req_ack, lsu_req_ack, drv_req_vld); end
        @(posedge clock);
        #1;
        reset_n = 1;
        settle();
        total++; if (lsu_req_ack !== 1'b1 || ifu_req_ack !== 1'b0) begin bad++; $display("FAIL areset_first_tie: got lsu=%b ifu=%b exp 1 0", lsu_req_ack, ifu_req_ack); end
        step();
        idle_inputs();
    endtask

    task automatic test_random();
        ent_t oq[$];
        logic last_lsu;
        logic rsp_hold;
        do_reset();
        last_lsu = 0;
        rsp_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            logic ie, le, e_wl, e_vld, e_acc, e_iv, e_lv, e_rack, hf;
            int   n_ifu, n_lsu;
            ent_t h;
            ifu_req_vld  = ($urandom_range(0, 2) != 0);
            lsu_req_vld  = ($urandom_range(0, 2) != 0);
            lsu_req_rnw  = 1'($urandom_range(0, 1));
            ifu_req_addr = $urandom;
            lsu_req_addr = $urandom;
            lsu_req_data = $urandom;
            ifu_flush    = ($urandom_range(0, 15) == 0);
            lsu_flush    = ($urandom_range(0, 15) == 0);
            drv_req_ack  = ($urandom_range(0, 3) != 0);
            ifu_rsp_ack  = ($urandom_range(0, 2) != 0);
            lsu_rsp_ack  = ($urandom_range(0, 2) != 0);
            if (!rsp_hold && oq.size() > 0)
                rsp_hold = ((c % 400) < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            drv_rsp_vld  = rsp_hold;
            drv_rsp_addr = rsp_hold ? oq[0].addr : $urandom;
            drv_rsp_data = rsp_hold ? oq[0].data : $urandom;

            ie    = ifu_req_vld & ~ifu_flush;
            le    = lsu_req_vld & ~lsu_flush;
            e_wl  = le & (~ie | ~last_lsu);
            e_vld = (ie | le) && (oq.size() < DEPTH);
            e_acc = e_vld & drv_req_ack;
            n_ifu = 0; n_lsu = 0;
            foreach (oq[i]) begin
                if (!oq[i].disc && !oq[i].own) n_ifu++;
                if (!oq[i].disc &&  oq[i].own) n_lsu++;
            end
            e_iv = 0; e_lv = 0; e_rack = 0;
            if (rsp_hold) begin
                h      = oq[0];
                hf     = h.own ? lsu_flush : ifu_flush;
                e_iv   = !h.disc && !hf && !h.own;
                e_lv   = !h.disc && !hf && h.own;
                e_rack = h.disc || hf || (h.own ? lsu_rsp_ack : ifu_rsp_ack);
            end
            settle();

            total++; if (drv_req_vld !== e_vld || ifu_req_ack !== (e_acc & ~e_wl) || lsu_req_ack !== (e_acc & e_wl)) begin bad++; $display("FAIL rnd_req c=%0d: got vld=%b ia=%b la=%b exp %b %b %b", c, drv_req_vld, ifu_req_ack, lsu_req_ack, e_vld, e_acc & ~e_wl, e_acc & e_wl); end
            if (e_vld) begin
                total++; if (drv_req_addr !== (e_wl ? lsu_req_addr : ifu_req_addr) || drv_req_rnw !== (e_wl ? lsu_req_rnw : 1'b1) || drv_req_data !== (e_wl ? lsu_req_data : 32'h0)) begin bad++; $display("FAIL rnd_req_mux c=%0d: got %h %b %h", c, drv_req_addr, drv_req_rnw, drv_req_data); end
            end
            total++; if (ifu_rsp_vld !== e_iv || lsu_rsp_vld !== e_lv || drv_rsp_ack !== e_rack) begin bad++; $display("FAIL rnd_rsp c=%0d: got iv=%b lv=%b ack=%b exp %b %b %b", c, ifu_rsp_vld, lsu_rsp_vld, drv_rsp_ack, e_iv, e_lv, e_rack); end
            if (e_iv || e_lv) begin
                total++; if ((e_lv ? lsu_rsp_data : ifu_rsp_data) !== oq[0].data) begin bad++; $display("FAIL rnd_rsp_data c=%0d: got %h exp %h", c, e_lv ? lsu_rsp_data : ifu_rsp_data, oq[0].data); end
            end
            total++; if (ifu_outstanding !== CW'(n_ifu) || lsu_outstanding !== CW'(n_lsu) || idle !== (oq.size() == 0)) begin bad++; $display("FAIL rnd_state c=%0d: got %0d/%0d idle=%b exp %0d/%0d %b", c, ifu_outstanding, lsu_outstanding, idle, n_ifu, n_lsu, oq.size() == 0); end

            foreach (oq[i]) begin
                if ((oq[i].own && lsu_flush) || (!oq[i].own && ifu_flush)) oq[i].disc = 1;
            end
            if (e_rack) begin
                void'(oq.pop_front());
                rsp_hold = 0;
            end
            if (e_acc) begin
                ent_t n;
                n.own  = e_wl;
                n.disc = 0;
                n.addr = drv_req_addr;
                n.data = $urandom;
                oq.push_back(n);
                last_lsu = e_wl;
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset_n = 0;
        test_reset();
        test_ifu_only();
        test_round_robin();
        test_fill();
        test_mixed_flush();
        test_flush_head();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
